serial_sub8: RTL and testbench

SERIAL_SUB8 -- requirements
Module: serial_sub8

---
 rtl/serial_sub8.sv | 123 ++++++++++++
 tb/tb_serial_sub8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: computes (a - b - borrow_in) one bit per clock,
// LSB first, and publishes the result and final borrow together on done.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             borrow_q, borrow_d;
  logic             diff_bit;
  logic             br_next;

  // State and datapath registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state logic; operands shift right so bit 0 is always the active bit,
  // and busy/done are computed from the next state so they come out of flops.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    y_d      = y_q;
    borrow_d = borrow_q;
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          y_d      = {diff_bit, res_q[WIDTH-1:1]};
          borrow_d = br_next;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign y      = y_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Bench for serial_sub8: directed literal cases plus randomized traffic
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_serial_sub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         borrow;

  int checks = 0;
  int fails  = 0;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .borrow_in(borrow_in),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts edges since the accepting edge (-1 when idle).
  int           t = -1;
  bit           en = 0;
  logic [W-1:0] m_y = '0;
  logic         m_borrow = 1'b0;
  logic [W-1:0] p_y = '0;
  logic         p_borrow = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      t = -1;
      m_y = '0;
      m_borrow = 1'b0;
      en = 1;
    end else if (t < 0) begin
      if (start === 1'b1) begin
        t = 0;
        p_y = W'(int'(a) - int'(b) - int'(borrow_in));
        p_borrow = (int'(a) < int'(b) + int'(borrow_in));
      end
    end else begin
      t++;
      if (t == W) begin
        m_y = p_y;
        m_borrow = p_borrow;
      end else if (t == W + 1) begin
        t = -1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (en) begin
      chk("busy", busy, (t >= 0 && t < W) ? 1 : 0);
      chk("done", done, (t == W) ? 1 : 0);
      chk("y", y, m_y);
      chk("borrow", borrow, m_borrow);
      chk("busy_done_excl", busy & done, 0);
    end
  end

  // Pulses start at the current time (caller positions on a negedge) and
  // checks latency, busy length and the literal result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ey, input logic eb, input string name);
    int j;
    int busy_n;
    bit got;
    start = 1'b1; a = ta; b = tb_v; borrow_in = tbin;
    @(negedge clk);
    start = 1'b0;
    j = 1; busy_n = 0; got = 0;
    while (j <= 40) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      j++;
    end
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_latency"}, j - 1, W);
    chk({name, "_busy_cycles"}, busy_n, W);
    chk({name, "_y"}, y, ey);
    chk({name, "_borrow"}, borrow, eb);
  endtask

  initial begin
    int dones;
    int first_j;
    int last_j;
    logic [W-1:0] seen_y;
    logic seen_b;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_y", y, 0);
    chk("reset_borrow", borrow, 0);

    // Start on the same edge reset is released.
    rst_n = 1'b1;
    run_op(8'd5, 8'd5, 1'b0, 8'd0, 1'b0, "5m5");
    @(negedge clk); run_op(8'd8, 8'd5, 1'b1, 8'd2, 1'b0, "8m5m1");
    @(negedge clk); run_op(8'd5, 8'd8, 1'b0, 8'd253, 1'b1, "5m8");
    @(negedge clk); run_op(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, "0m0m1");
    @(negedge clk); run_op(8'd255, 8'd0, 1'b0, 8'd255, 1'b0, "255m0");

    // Disturb inputs and re-pulse start mid-run.
    @(negedge clk);
    start = 1'b1; a = 8'd20; b = 8'd7; borrow_in = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'd200; b = 8'd100; borrow_in = 1'b1;
    dones = 0; seen_y = '0; seen_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        seen_y = y;
        seen_b = borrow;
      end
    end
    chk("disturb_done_count", dones, 1);
    chk("disturb_y", seen_y, 13);
    chk("disturb_borrow", seen_b, 0);

    // Reset in the middle of RUN, with start asserted during reset.
    start = 1'b1; a = 8'd50; b = 8'd3; borrow_in = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_y", y, 0);
    chk("midrst_borrow", borrow, 0);
    rst_n = 1'b1; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(8'd8, 8'd5, 1'b1, 8'd2, 1'b0, "after_rst");

    // Start held high for 30 cycles: back-to-back operations.
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd1; borrow_in = 1'b0;
    dones = 0; first_j = -1; last_j = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 30) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        chk("held_y", y, 99);
        if (last_j >= 0) chk("held_spacing", j - last_j, W + 2);
        if (first_j < 0) first_j = j;
        last_j = j;
      end
    end
    chk("held_done_count", dones, 3);
    chk("held_first_latency", first_j - 1, W);

    // Randomized traffic, checked by the per-cycle model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
      rst_n     = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
